// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared widths, owner encodings and read-tag type
`ifndef UART_WIDTH
`define UART_WIDTH 8
`endif
`ifndef ADDR
`define ADDR 10
`endif
package ram_port_arbiter_pkg;
  localparam int DATAW = `UART_WIDTH;
  localparam int ADDRW = `ADDR;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;
  typedef struct packed {
    logic valid;
    logic port_b;
  } rd_tag_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two requester ports plus the RAM side of the arbiter
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;
  logic             a_req, a_lock, a_we, a_gnt, a_rvalid;
  logic [ADDRW-1:0] a_addr;
  logic [DATAW-1:0] a_din, a_rdata;
  logic             b_req, b_lock, b_we, b_gnt, b_rvalid;
  logic [ADDRW-1:0] b_addr;
  logic [DATAW-1:0] b_din, b_rdata;
  logic             ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_din, ram_dout;
  logic [1:0]       owner;
  modport master (
    output a_req, a_lock, a_we, a_addr, a_din,
    output b_req, b_lock, b_we, b_addr, b_din,
    output ram_dout,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_din, owner
  );
  modport slave (
    input  a_req, a_lock, a_we, a_addr, a_din,
    input  b_req, b_lock, b_we, b_addr, b_din,
    input  ram_dout,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_din, owner
  );
endinterface

// File: rtl/ram_port_arbiter_arb_rd_tag_pipe.sv
// arb_rd_tag_pipe: RD_LAT-deep shift register of read tags aligned with RAM read latency
module arb_rd_tag_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);
  rd_tag_t pipe [RD_LAT];
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign out_tag = pipe[RD_LAT-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter with bounded burst lock sharing one single-port RAM
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  logic [1:0]    owner, owner_nx;
  logic [HW-1:0] hold, hold_nx;
  logic          last_b, sel_a, sel_b, own_req, own_we, own_lock, served_b, keep, both;
  rd_tag_t       push_tag, ret_tag;
  assign sel_a    = owner == OWN_A;
  assign sel_b    = owner == OWN_B;
  assign own_req  = sel_a ? bus.a_req  : sel_b & bus.b_req;
  assign own_we   = sel_a ? bus.a_we   : sel_b & bus.b_we;
  assign own_lock = sel_a ? bus.a_lock : sel_b & bus.b_lock;
  // the current owner counts as served this cycle; when idle fall back to the stored port
  assign served_b = sel_b | (~sel_a & last_b);
  assign keep     = own_lock && hold < HMAX;
  assign both     = bus.a_req & bus.b_req;
  always_comb begin
    owner_nx = both ? (keep ? owner : (served_b ? OWN_A : OWN_B))
             : bus.a_req ? OWN_A : bus.b_req ? OWN_B : OWN_NONE;
    hold_nx  = (both & keep) ? hold + 1'b1 : (owner_nx == owner) ? hold : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      owner  <= OWN_NONE;
      hold   <= '0;
      last_b <= 1'b1;
    end else begin
      owner  <= owner_nx;
      hold   <= hold_nx;
      last_b <= served_b;
    end
  assign bus.owner    = owner;
  assign bus.a_gnt    = owner[0];
  assign bus.b_gnt    = owner[1];
  assign bus.ram_we   = own_req & own_we;
  assign bus.ram_addr = sel_a ? bus.a_addr : sel_b ? bus.b_addr : '0;
  assign bus.ram_din  = sel_a ? bus.a_din  : sel_b ? bus.b_din  : '0;
  assign push_tag     = '{valid: own_req & ~own_we, port_b: sel_b};
  arb_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag (
    .clk(clk),
    .rst(rst),
    .in_tag(push_tag),
    .out_tag(ret_tag)
  );
  assign bus.a_rvalid = ret_tag.valid & ~ret_tag.port_b;
  assign bus.b_rvalid = ret_tag.valid & ret_tag.port_b;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;
endmodule
